// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// Optional statistics counters are enabled with FIFO_READER_STATS_EN.
package fifo_reader_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_t;

    localparam int BUF_DEPTH = 2;
    localparam int STAT_W    = 32;

    // Saturating accumulate for the event counters.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] acc,
                                                   input logic [1:0]        inc);
        logic [STAT_W:0] sum;
        sum = {1'b0, acc} + {{(STAT_W-1){1'b0}}, inc};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_reader_obuf.sv
// Two-entry in-order output buffer; the head entry drives the stream directly
// so the output data is always registered.
module fifo_reader_obuf
    import fifo_reader_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push_i,
    input  logic [width-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [width-1:0] data_o,
    output logic [1:0]       count_o,
    output logic             valid_o
);

    logic [width-1:0] ent_q [BUF_DEPTH];
    logic [width-1:0] ent_d [BUF_DEPTH];
    logic [1:0]       cnt_q, cnt_d;

    // Clear wins over a simultaneous push: that word is discarded.
    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_i && (cnt_q != 2'd0)) begin
                ent_d[0] = ent_q[1];
                cnt_d    = cnt_q - 2'd1;
            end
            if (push_i && (cnt_d < 2'(BUF_DEPTH))) begin
                ent_d[cnt_d[0]] = push_data_i;
                cnt_d           = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = ent_q[0];
    assign count_o = cnt_q;
    assign valid_o = (cnt_q != 2'd0);

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: drains a synchronous FIFO into a valid/ready stream,
// mirrors occupancy from write strobes, and supports flush. Stats: FIFO_READER_STATS_EN.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int  depth = 16,
    parameter int  width = 16,
    localparam int LW    = $clog2(depth) + 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             fifo_write,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data_out,
    output logic             fifo_read,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             flush,
    output logic             flush_busy,
    output logic             flush_done,
    output logic [LW-1:0]    level
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [STAT_W-1:0] words_out,
    output logic [STAT_W-1:0] words_dropped
`endif
);

    rd_state_t     state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic          inflight_q;
    logic          flush_done_q, flush_done_d;

    logic          wr_acc;
    logic          rd_ok;
    logic          credit_ok;
    logic [2:0]    credit_use;
    logic          push, pop, clear;
    logic [1:0]    buf_cnt;

    assign wr_acc = fifo_write && !fifo_full;
    // The mirrored level guards against reading on a flag that has not yet caught up.
    assign rd_ok  = (level_q != '0) && !fifo_empty;
    assign pop    = m_valid && m_ready;

    assign credit_use = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok  = (credit_use < 3'(BUF_DEPTH));

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        fifo_read    = 1'b0;
        push         = 1'b0;
        clear        = 1'b0;
        case (state_q)
            RUN: begin
                fifo_read = rd_ok && credit_ok;
                push      = inflight_q;
                if (flush) begin
                    state_d = FLUSH;
                    clear   = 1'b1;
                end
            end
            FLUSH: begin
                fifo_read = rd_ok;
                if ((level_q == '0) && !inflight_q && !flush) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign level_d = level_q + LW'(wr_acc) - LW'(fifo_read);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= RUN;
            level_q      <= '0;
            inflight_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            inflight_q   <= fifo_read;
            flush_done_q <= flush_done_d;
        end
    end

    fifo_reader_obuf #(
        .width (width)
    ) u_obuf (
        .clk         (clk),
        .rst_        (rst_),
        .push_i      (push),
        .push_data_i (fifo_data_out),
        .pop_i       (pop),
        .clear_i     (clear),
        .data_o      (m_data),
        .count_o     (buf_cnt),
        .valid_o     (m_valid)
    );

    assign flush_busy = (state_q == FLUSH);
    assign flush_done = flush_done_q;
    assign level      = level_q;

`ifdef FIFO_READER_STATS_EN
    logic [STAT_W-1:0] words_out_q, words_dropped_q;
    logic [1:0]        drop_amt;

    // On flush entry everything left in the buffer (plus a same-edge capture) is lost.
    always_comb begin
        drop_amt = 2'd0;
        if (clear) begin
            drop_amt = buf_cnt + {1'b0, push} - {1'b0, pop};
        end else if (state_q == FLUSH) begin
            drop_amt = {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            words_out_q     <= '0;
            words_dropped_q <= '0;
        end else begin
            words_out_q     <= sat_add(words_out_q, {1'b0, pop});
            words_dropped_q <= sat_add(words_dropped_q, drop_amt);
        end
    end

    assign words_out     = words_out_q;
    assign words_dropped = words_dropped_q;
`endif

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side controller for the team's synchronous FIFO (registered `fifo_empty`/`fifo_full`, one-cycle registered read data).
- Drains the FIFO into a valid/ready output stream at one word per cycle, through a 2-entry output buffer.
- Mirrors FIFO occupancy from the observed write strobes, because the FIFO's registered flags lag pointer updates.
- Provides a flush mode that discards FIFO contents.

Parameters:
- depth, 16, FIFO depth in words; must equal the FIFO's depth and be a power of 2, >= 2.
- width, 16, data word width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_  input  1  asynchronous, active-low reset; shared with the FIFO.
- fifo_write  input  1  monitored copy of the FIFO write strobe.
- fifo_full  input  1  FIFO full flag.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data_out  input  width  FIFO read data, valid the cycle after an accepted read.
- fifo_read  output  1  read strobe to the FIFO.
- m_data  output  width  output stream data.
- m_valid  output  1  output stream valid.
- m_ready  input  1  output stream ready.
- flush  input  1  level-sensitive flush request.
- flush_busy  output  1  high while in FLUSH state.
- flush_done  output  1  one-cycle pulse when a flush completes.
- level  output  $clog2(depth)+1  mirrored FIFO occupancy.

Behaviour:
- Reset (async, rst_=0):
  - level=0, inflight=0, buffer empty, state=RUN.
  - fifo_read=0, m_valid=0, m_data=0, flush_busy=0, flush_done=0.
- Write acceptance: wr_acc = fifo_write && !fifo_full. This is the exact condition under which the FIFO stores a word.
- Read acceptance: rd_acc = fifo_read, and fifo_read is only asserted when level>0 && !fifo_empty. The FIFO therefore never ignores a read, and a stale-empty cycle simply stalls.
- level update: level_next = level + wr_acc - rd_acc. Simultaneous write and read leave it unchanged. Width $clog2(depth)+1; never exceeds depth and never goes below 0.
- inflight: 1-bit register, set to rd_acc every cycle. Data is captured from fifo_data_out when inflight=1.
- Output buffer: 2-entry, in-order.
  - m_data/m_valid are driven from the head entry (registered, no combinational path from fifo_data_out).
  - pop = m_valid && m_ready.
- RUN read credit: fifo_read is asserted only if (buf_cnt + inflight - pop) < 2. This sustains 1 word/cycle with m_ready held high.
- Latency: from an accepted read, m_valid rises 2 edges later (first edge: FIFO registers data; second edge: buffer capture).
- m_data must stay stable while m_valid=1 && m_ready=0.
- FSM states:
  - RUN: normal drain. flush=1 -> FLUSH on the next edge.
  - FLUSH:
    - Output buffer cleared on entry; m_valid=0; flush_busy=1.
    - fifo_read asserted whenever level>0 && !fifo_empty, ignoring credit.
    - Returning in-flight data is discarded.
    - Exits to RUN when level==0 && inflight==0 && flush==0; flush_done pulses for 1 cycle on that edge.
    - Writes arriving during FLUSH are also drained.
- flush asserted while already in FLUSH: stay in FLUSH.
- Reset mid-operation: immediate return to reset values. The FIFO resets on the same rst_, so the mirror stays consistent.

Optional Feature:
- FIFO_READER_STATS_EN: adds ports words_out (output, 32) and words_dropped (output, 32).
  - words_out counts pops; words_dropped counts words discarded in FLUSH (captured data plus buffer contents cleared on entry).
  - Both saturate at 2^32-1, reset to 0, and are not cleared by flush.
- Without the macro: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fifo_reader_pkg:
  - typedef enum logic {RUN, FLUSH} rd_state_t.
  - localparam BUF_DEPTH=2.
  - localparam STAT_W=32.
- Sub-module fifo_reader_obuf: the 2-entry output buffer (push, pop, clear, data, count, valid).
- FSM, occupancy mirror, credit logic and stats stay in fifo_reader.

Test Plan:
- Write 0x0001..0x0004 back-to-back with m_ready=1 -> m_data emits 0x0001..0x0004 in order on 4 consecutive cycles; first m_valid 2 cycles after first fifo_read; level returns to 0.
- Fill 16 words with m_ready=0 -> exactly 2 fifo_read pulses, level=14, m_data=first word held stable; raise m_ready -> remaining 16 words in order, no gaps after restart.
- Write 1 word, then simultaneous write and read every cycle for 20 cycles -> level constant at 1; no fifo_read while fifo_empty=1; no duplicated or lost words.
- 10 words queued, 2 in buffer, pulse flush -> m_valid=0 next cycle; flush_busy=1; 8 reads issued; flush_done single pulse; level=0; words_dropped=10 with FIFO_READER_STATS_EN.
- Assert rst_=0 mid-stream with 5 words queued -> immediately m_valid=0, fifo_read=0, level=0; post-reset writes drain correctly.
- Write to a full FIFO (17th write while fifo_full=1) -> level stays 16 and only 16 words are emitted.
